// File: rtl/ft245_pkg.sv
// Shared FSM encoding, widths and the strobe timer load helper for the FT245 bridge.
package ft245_pkg;

   localparam int BYTE_W  = 8;
   localparam int STATS_W = 16;
   localparam int TIMER_W = 8;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_RD_STROBE  = 3'd1,
      S_RD_RECOVER = 3'd2,
      S_WR_STROBE  = 3'd3,
      S_WR_RECOVER = 3'd4
   } state_t;

   // Timer counts down to zero, so a phase of N cycles loads N-1.
   function automatic logic [TIMER_W-1:0] timer_load(input int cycles);
      return TIMER_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/ft245_fifo.sv
// First-word-fall-through sync FIFO, depth 2**AW, zero-latency head on pop_dat while pop_vld.
// Push is dropped when full (push_rdy=0); simultaneous push and pop keeps the count.
module ft245_fifo
   import ft245_pkg::*;
#(
   parameter int AW = 4,
   parameter int DW = BYTE_W
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_vld,
   input  logic [DW-1:0] push_dat,
   output logic          push_rdy,
   output logic          pop_vld,
   output logic [DW-1:0] pop_dat,
   input  logic          pop_rdy
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          push;
   logic          pop;

   // Count never exceeds DEPTH, so its top bit alone marks full.
   assign push_rdy = !cnt_q[AW];
   assign pop_vld  = (cnt_q != '0);
   assign pop_dat  = mem[rptr_q];
   assign push     = push_vld && push_rdy;
   assign pop      = pop_rdy && pop_vld;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      if (push && !pop)
         cnt_d = cnt_q + (AW+1)'(1);
      else if (pop && !push)
         cnt_d = cnt_q - (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr_q] <= push_dat;
   end

endmodule

// File: rtl/ft245_bridge.sv
// UART valid/ready <-> FT245 strobe bridge; TX byte reaches uart_wr one edge after acceptance, RX byte visible the edge it is sampled.
// Backpressure via tx_ready (TX FIFO full) and by withholding reads while RX FIFO is full; FT245_STATS_EN adds rx_count/tx_count.
module ft245_bridge
   import ft245_pkg::*;
#(
   parameter int FIFO_AW  = 4,
   parameter int RD_PULSE = 4,
   parameter int WR_PULSE = 4,
   parameter int RECOVERY = 4
) (
   input  logic               clk,
   input  logic               reset,
`ifdef FT245_STATS_EN
   output logic [STATS_W-1:0] rx_count,
   output logic [STATS_W-1:0] tx_count,
`endif
   input  logic [BYTE_W-1:0]  tx_data,
   input  logic               tx_valid,
   output logic               tx_ready,
   output logic [BYTE_W-1:0]  rx_data,
   output logic               rx_valid,
   input  logic               rx_ready,
   input  logic [BYTE_W-1:0]  uart_rdata,
   output logic [BYTE_W-1:0]  uart_wdata,
   input  logic               uart_txe_n,
   input  logic               uart_rxf_n,
   output logic               uart_rd,
   output logic               uart_wr
);

   state_t              state_q, state_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic                rd_q, rd_d;
   logic                wr_q, wr_d;
   logic [BYTE_W-1:0]   wdata_q, wdata_d;
   logic                arb_q, arb_d;

   logic                rx_push;
   logic                rx_push_rdy;
   logic                tx_pop;
   logic                tx_pop_vld;
   logic [BYTE_W-1:0]   tx_head;
   logic                rd_ok;
   logic                wr_ok;

   ft245_fifo #(.AW(FIFO_AW), .DW(BYTE_W)) u_rx_fifo (
      .clk      (clk),
      .reset    (reset),
      .push_vld (rx_push),
      .push_dat (uart_rdata),
      .push_rdy (rx_push_rdy),
      .pop_vld  (rx_valid),
      .pop_dat  (rx_data),
      .pop_rdy  (rx_ready)
   );

   ft245_fifo #(.AW(FIFO_AW), .DW(BYTE_W)) u_tx_fifo (
      .clk      (clk),
      .reset    (reset),
      .push_vld (tx_valid),
      .push_dat (tx_data),
      .push_rdy (tx_ready),
      .pop_vld  (tx_pop_vld),
      .pop_dat  (tx_head),
      .pop_rdy  (tx_pop)
   );

   // Only IDLE looks at these; the RX FIFO cannot fill mid-strobe since the strobe is its only writer.
   assign rd_ok = !uart_rxf_n && rx_push_rdy;
   assign wr_ok = !uart_txe_n && tx_pop_vld;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      arb_d   = arb_q;
      rx_push = 1'b0;
      tx_pop  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rd_ok && (!wr_ok || !arb_q)) begin
               state_d = S_RD_STROBE;
               rd_d    = 1'b1;
               timer_d = timer_load(RD_PULSE);
            end else if (wr_ok) begin
               state_d = S_WR_STROBE;
               wr_d    = 1'b1;
               timer_d = timer_load(WR_PULSE);
               wdata_d = tx_head;
               tx_pop  = 1'b1;
            end
         end
         S_RD_STROBE: begin
            if (timer_q == '0) begin
               rx_push = 1'b1;
               rd_d    = 1'b0;
               arb_d   = !arb_q;
               state_d = S_RD_RECOVER;
               timer_d = timer_load(RECOVERY);
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         S_WR_STROBE: begin
            if (timer_q == '0) begin
               wr_d    = 1'b0;
               arb_d   = !arb_q;
               state_d = S_WR_RECOVER;
               timer_d = timer_load(RECOVERY);
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         S_RD_RECOVER, S_WR_RECOVER: begin
            if (timer_q == '0)
               state_d = S_IDLE;
            else
               timer_d = timer_q - TIMER_W'(1);
         end
         default: begin
            state_d = S_IDLE;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            timer_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         arb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         arb_q   <= arb_d;
      end
   end

   assign uart_rd    = rd_q;
   assign uart_wr    = wr_q;
   assign uart_wdata = wdata_q;

`ifdef FT245_STATS_EN
   logic [STATS_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [STATS_W-1:0] tx_cnt_q, tx_cnt_d;

   always_comb begin
      rx_cnt_d = rx_cnt_q;
      tx_cnt_d = tx_cnt_q;
      if (rx_push)
         rx_cnt_d = rx_cnt_q + STATS_W'(1);
      if ((state_q == S_WR_STROBE) && (timer_q == '0))
         tx_cnt_d = tx_cnt_q + STATS_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_cnt_q <= '0;
         tx_cnt_q <= '0;
      end else begin
         rx_cnt_q <= rx_cnt_d;
         tx_cnt_q <= tx_cnt_d;
      end
   end

   assign rx_count = rx_cnt_q;
   assign tx_count = tx_cnt_q;
`endif

endmodule

// File: tb/tb_ft245_bridge.sv
// Scoreboard bench for ft245_bridge: pad-side host/device model, expected-byte queues and strobe-timing monitor.
module tb_ft245_bridge;

   localparam int RD_P = 4;
   localparam int WR_P = 4;
   localparam int REC  = 4;
   localparam logic [7:0] LOG_RD = 8'h72;
   localparam logic [7:0] LOG_WR = 8'h77;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] tx_data, rx_data, uart_rdata, uart_wdata;
   logic       tx_valid, tx_ready, rx_valid, rx_ready;
   logic       uart_txe_n, uart_rxf_n, uart_rd, uart_wr;
`ifdef FT245_STATS_EN
   logic [15:0] rx_count, tx_count;
`endif

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [7:0] host_q[$];
   logic [7:0] exp_wr_q[$];
   logic [7:0] exp_rx_q[$];
   logic [7:0] log_q[$];
   int         wr_starts[$];

   int  rd_cnt = 0, wr_cnt = 0, rd_done = 0, wr_done = 0;
   int  wr_len = 0, rd_len = 0, last_end = 0;
   bit  have_end = 0, wr_prev = 0, rd_prev = 0;
   bit  cut_wr = 0, cut_rd = 0, wr_stable = 1;
   logic [7:0] wr_cur;
   logic [7:0] mb;

   ft245_bridge dut (
      .clk        (clk),
      .reset      (reset),
`ifdef FT245_STATS_EN
      .rx_count   (rx_count),
      .tx_count   (tx_count),
`endif
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .uart_rdata (uart_rdata),
      .uart_wdata (uart_wdata),
      .uart_txe_n (uart_txe_n),
      .uart_rxf_n (uart_rxf_n),
      .uart_rd    (uart_rd),
      .uart_wr    (uart_wr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int expv);
      n_vec++;
      if (act != expv) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // Host side of the device: holds bytes for the SoC, head presented on the data pins.
   task automatic pad_update();
      uart_rxf_n = (host_q.size() == 0);
      uart_rdata = (host_q.size() != 0) ? host_q[0] : 8'h00;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Monitor: strobe timing, write data, pad reads, RX pops, TX acceptances.
   always @(negedge clk) begin
      if (uart_wr === 1'b1) begin
         if (!wr_prev) begin
            chk("wr_excl", int'(uart_rd), 0);
            if (have_end) chk("wr_recovery_gap", int'((cyc - last_end) >= REC + 1), 1);
            chk("wr_expected", int'(exp_wr_q.size() != 0), 1);
            if (exp_wr_q.size() != 0) chk("wr_data", int'(uart_wdata), int'(exp_wr_q.pop_front()));
            wr_cur    = uart_wdata;
            wr_len    = 0;
            wr_stable = 1;
            cut_wr    = 0;
            wr_cnt++;
            log_q.push_back(LOG_WR);
            wr_starts.push_back(cyc);
         end
         wr_len++;
         if (uart_wdata !== wr_cur) wr_stable = 0;
         if (reset) cut_wr = 1;
      end else if (wr_prev) begin
         if (!cut_wr) begin
            chk("wr_pulse_len", wr_len, WR_P);
            chk("wr_data_stable", int'(wr_stable), 1);
            wr_done++;
         end
         last_end = cyc;
         have_end = 1;
      end

      if (uart_rd === 1'b1) begin
         if (!rd_prev) begin
            chk("rd_excl", int'(uart_wr), 0);
            if (have_end) chk("rd_recovery_gap", int'((cyc - last_end) >= REC + 1), 1);
            rd_len = 0;
            cut_rd = 0;
            rd_cnt++;
            log_q.push_back(LOG_RD);
         end
         rd_len++;
         if (reset) cut_rd = 1;
      end else if (rd_prev) begin
         if (!cut_rd) begin
            chk("rd_pulse_len", rd_len, RD_P);
            chk("rd_expected", int'(host_q.size() != 0), 1);
            if (host_q.size() != 0) begin
               mb = host_q.pop_front();
               exp_rx_q.push_back(mb);
               pad_update();
            end
            chk("rx_valid_after_rd", int'(rx_valid), 1);
            rd_done++;
         end
         last_end = cyc;
         have_end = 1;
      end

      if (!reset && rx_valid === 1'b1 && rx_ready) begin
         chk("rx_expected", int'(exp_rx_q.size() != 0), 1);
         if (exp_rx_q.size() != 0) chk("rx_data", int'(rx_data), int'(exp_rx_q.pop_front()));
      end

      if (!reset && tx_valid && tx_ready === 1'b1) exp_wr_q.push_back(tx_data);

      if (reset) begin
         exp_wr_q.delete();
         exp_rx_q.delete();
         have_end = 0;
         wr_done  = 0;
         rd_done  = 0;
      end

      wr_prev = (uart_wr === 1'b1);
      rd_prev = (uart_rd === 1'b1);
   end

   initial begin
      #600000;
      n_err++;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1);
   end

   initial begin
      int acc;
      int base_a;
      int base_b;
      bit found;

      reset      = 1'b1;
      tx_valid   = 1'b0;
      tx_data    = 8'h00;
      rx_ready   = 1'b0;
      uart_txe_n = 1'b1;
      pad_update();
      idle(3);
      reset = 1'b0;

      // Reset state
      chk("rst_uart_rd", int'(uart_rd), 0);
      chk("rst_uart_wr", int'(uart_wr), 0);
      chk("rst_uart_wdata", int'(uart_wdata), 0);
      chk("rst_tx_ready", int'(tx_ready), 1);
      chk("rst_rx_valid", int'(rx_valid), 0);

      // Single writes: latency and back-to-back period
      uart_txe_n = 1'b0;
      base_a = wr_cnt;
      base_b = rd_cnt;
      wr_starts.delete();
      tx_valid = 1'b1;
      tx_data  = 8'hA5;
      tick();
      acc = cyc;
      tx_data = 8'h5A;
      tick();
      tx_valid = 1'b0;
      idle(30);
      chk("wr_strobe_count", wr_cnt - base_a, 2);
      chk("wr_no_read", rd_cnt - base_b, 0);
      if (wr_starts.size() >= 2) begin
         chk("wr_latency", wr_starts[0] - acc, 1);
         chk("wr_period", wr_starts[1] - wr_starts[0], 1 + WR_P + REC);
      end

      // Single read
      rx_ready = 1'b0;
      base_b = rd_cnt;
      host_q.push_back(8'h3C);
      pad_update();
      idle(30);
      chk("rd_strobe_count", rd_cnt - base_b, 1);
      chk("rd_rx_valid", int'(rx_valid), 1);
      chk("rd_rx_data", int'(rx_data), 8'h3C);
      rx_ready = 1'b1;
      idle(3);
      chk("rd_drained", int'(rx_valid), 0);

      // Arbitration: both eligible from a fresh reset alternate starting with read
      do_reset();
      uart_txe_n = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 8'h01;
      tick();
      tx_data  = 8'h02;
      tick();
      tx_valid = 1'b0;
      idle(2);
      log_q.delete();
      host_q.push_back(8'h10);
      host_q.push_back(8'h11);
      pad_update();
      uart_txe_n = 1'b0;
      idle(60);
      chk("arb_count", log_q.size(), 4);
      for (int i = 0; i < log_q.size() && i < 4; i++)
         chk("arb_order", int'(log_q[i]), int'((i % 2 == 0) ? LOG_RD : LOG_WR));
      chk("arb_rx_drained", exp_rx_q.size(), 0);

      // TX full boundary
      do_reset();
      uart_txe_n = 1'b1;
      tx_valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         tx_data = 8'(8'h40 + i);
         tick();
      end
      tx_valid = 1'b0;
      chk("tx_full_ready", int'(tx_ready), 0);
      chk("tx_full_accepted", exp_wr_q.size(), 16);
      uart_txe_n = 1'b0;
      idle(16 * (1 + WR_P + REC) + 20);
      chk("tx_full_drained", exp_wr_q.size(), 0);
      chk("tx_full_ready_back", int'(tx_ready), 1);

      // RX full boundary
      rx_ready = 1'b0;
      base_b = rd_cnt;
      for (int i = 0; i < 20; i++) host_q.push_back(8'($urandom));
      pad_update();
      idle(20 * (1 + RD_P + REC) + 30);
      chk("rx_full_reads", rd_cnt - base_b, 16);
      chk("rx_full_host_left", host_q.size(), 4);
      chk("rx_full_valid", int'(rx_valid), 1);
      rx_ready = 1'b1;
      idle(80);
      chk("rx_full_host_drained", host_q.size(), 0);
      chk("rx_full_fifo_drained", exp_rx_q.size(), 0);

      // Reset during cycle 2 of a write strobe
      uart_txe_n = 1'b0;
      tx_valid = 1'b1;
      tx_data  = 8'h77;
      tick();
      tx_valid = 1'b0;
      found = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (uart_wr) begin
            found = 1;
            break;
         end
      end
      chk("mid_wr_seen", int'(found), 1);
      tick();
      reset = 1'b1;
      tick();
      chk("mid_rst_wr", int'(uart_wr), 0);
      chk("mid_rst_tx_ready", int'(tx_ready), 1);
      reset = 1'b0;
      base_a = wr_cnt + rd_cnt;
      idle(30);
      chk("mid_rst_no_strobe", wr_cnt + rd_cnt - base_a, 0);

      // Randomised traffic in both directions
      for (int i = 0; i < 2500; i++) begin
         tx_valid = ($urandom_range(0, 2) == 0);
         tx_data  = 8'($urandom);
         if ($urandom_range(0, 7) == 0) uart_txe_n = ~uart_txe_n;
         if ($urandom_range(0, 11) == 0 && host_q.size() < 40) begin
            host_q.push_back(8'($urandom));
            pad_update();
         end
         rx_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      tx_valid   = 1'b0;
      uart_txe_n = 1'b0;
      rx_ready   = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (exp_wr_q.size() == 0 && host_q.size() == 0 && exp_rx_q.size() == 0 &&
             !uart_wr && !uart_rd && !rx_valid)
            break;
      end
      chk("rand_tx_drained", exp_wr_q.size(), 0);
      chk("rand_host_drained", host_q.size(), 0);
      chk("rand_rx_drained", exp_rx_q.size(), 0);

`ifdef FT245_STATS_EN
      chk("stats_tx_count", int'(tx_count), wr_done & 16'hFFFF);
      chk("stats_rx_count", int'(rx_count), rd_done & 16'hFFFF);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
